// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction and data requesters, data first with a starvation bound
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  localparam logic [3:0] lim = 4'(STARVE_LIMIT);
  state_t state;
  logic abort;
  logic [3:0] cnt;
  logic grant_i, owner_valid, done;
  always_comb begin
    grant_i = imemory_valid && (!dmemory_valid || cnt == lim);
    owner_valid = state == BUSY_I ? imemory_valid : dmemory_valid;
    done = !rst && memory_ready && !abort && owner_valid;
  end
  assign imemory_ready = done && state == BUSY_I;
  assign dmemory_ready = done && state == BUSY_D;
  assign imemory_rdata = memory_rdata;
  assign dmemory_rdata = memory_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      abort <= 1'b0;
      cnt <= 4'd0;
      memory_valid <= 1'b0;
      memory_instr <= 1'b0;
      memory_addr <= 32'd0;
      memory_wdata <= 32'd0;
      memory_wstrb <= 4'd0;
    end else if (state == IDLE) begin
      if (imemory_valid || dmemory_valid) begin
        state <= grant_i ? BUSY_I : BUSY_D;
        abort <= 1'b0;
        cnt <= (grant_i || !imemory_valid) ? 4'd0 : (cnt == lim ? cnt : cnt + 4'd1);
        memory_valid <= 1'b1;
        memory_instr <= grant_i ? imemory_instr : dmemory_instr;
        memory_addr <= grant_i ? imemory_addr : dmemory_addr;
        memory_wdata <= grant_i ? imemory_wdata : dmemory_wdata;
        memory_wstrb <= grant_i ? imemory_wstrb : dmemory_wstrb;
      end
    end else if (memory_ready) begin
      state <= IDLE;
      memory_valid <= 1'b0;
    end else if (!owner_valid) begin
      abort <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; stimulus queues expected grants/completions, a negedge monitor checks them
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic imemory_valid = 1'b0, imemory_instr = 1'b0, imemory_ready;
  logic [31:0] imemory_addr = '0, imemory_wdata = '0, imemory_rdata;
  logic [3:0] imemory_wstrb = '0;
  logic dmemory_valid = 1'b0, dmemory_instr = 1'b0, dmemory_ready;
  logic [31:0] dmemory_addr = '0, dmemory_wdata = '0, dmemory_rdata;
  logic [3:0] dmemory_wstrb = '0;
  logic memory_valid, memory_instr, memory_ready = 1'b0;
  logic [31:0] memory_addr, memory_wdata, memory_rdata = '0;
  logic [3:0] memory_wstrb;
  int passed = 0, total = 0;
  logic [68:0] eg[$];
  logic [33:0] ed[$];
  logic prev_mv = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imemory_valid(imemory_valid), .imemory_instr(imemory_instr), .imemory_addr(imemory_addr),
    .imemory_wdata(imemory_wdata), .imemory_wstrb(imemory_wstrb), .imemory_rdata(imemory_rdata),
    .imemory_ready(imemory_ready),
    .dmemory_valid(dmemory_valid), .dmemory_instr(dmemory_instr), .dmemory_addr(dmemory_addr),
    .dmemory_wdata(dmemory_wdata), .dmemory_wstrb(dmemory_wstrb), .dmemory_rdata(dmemory_rdata),
    .dmemory_ready(dmemory_ready),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  always @(negedge clk) begin
    if (memory_valid && !prev_mv) begin
      if (eg.size() == 0) check("unexpected_grant", {memory_instr, memory_addr, memory_wdata, memory_wstrb}, '0);
      else check("grant", {memory_instr, memory_addr, memory_wdata, memory_wstrb}, eg.pop_front());
    end
    if (imemory_ready || dmemory_ready) begin
      if (ed.size() == 0) check("unexpected_ready", {35'd0, imemory_ready, dmemory_ready, memory_rdata}, '0);
      else check("completion", {35'd0, imemory_ready, dmemory_ready, imemory_ready ? imemory_rdata : dmemory_rdata},
                 {35'd0, ed.pop_front()});
    end
    prev_mv = memory_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_i(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = a; imemory_wdata = wd; imemory_wstrb = ws;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = a; dmemory_wdata = wd; dmemory_wstrb = ws;
  endtask

  task automatic exp_grant(input logic ins, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    eg.push_back({ins, a, wd, ws});
  endtask

  task automatic exp_done(input bit is_i, input logic [31:0] rd);
    ed.push_back({is_i, !is_i, rd});
  endtask

  task automatic wait_grant();
    int n = 0;
    while (memory_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("grant_timeout", {68'd0, memory_valid}, 69'd1);
  endtask

  task automatic serve(input int lat, input logic [31:0] rd, input bit drop_i, input bit drop_d);
    wait_grant();
    repeat (lat) tick();
    memory_ready = 1'b1;
    memory_rdata = rd;
    tick();
    memory_ready = 1'b0;
    if (drop_i) imemory_valid = 1'b0;
    if (drop_d) dmemory_valid = 1'b0;
    check("valid_clear_after_ready", {68'd0, memory_valid}, 69'd0);
  endtask

  initial begin
    memory_rdata = 32'h5A5A_5A5A;
    tick(); tick();
    check("reset_outputs", {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb, imemory_ready, dmemory_ready}, '0);
    check("reset_rdata_pass", {5'd0, imemory_rdata, dmemory_rdata}, {5'd0, 32'h5A5A_5A5A, 32'h5A5A_5A5A});
    rst = 1'b0;
    tick();
    // single instruction read
    drive_i(32'h100, 32'h0, 4'h0);
    exp_grant(1'b1, 32'h100, 32'h0, 4'h0);
    exp_done(1'b1, 32'hDEAD_BEEF);
    tick();
    check("req_latency", {memory_valid, memory_instr, memory_addr, 35'd0}, {1'b1, 1'b1, 32'h100, 35'd0});
    serve(2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tick();
    // data write wins over simultaneous instruction read
    drive_i(32'h300, 32'h0, 4'h0);
    drive_d(32'h2000, 32'h1234_5678, 4'hF);
    exp_grant(1'b0, 32'h2000, 32'h1234_5678, 4'hF);
    exp_done(1'b0, 32'h0000_0000);
    exp_grant(1'b1, 32'h300, 32'h0, 4'h0);
    exp_done(1'b1, 32'hCAFE_0001);
    serve(0, 32'h0, 1'b0, 1'b1);
    tick();
    check("gap_then_grant", {68'd0, memory_valid}, 69'd1);
    serve(0, 32'hCAFE_0001, 1'b1, 1'b0);
    tick();
    // starvation bound: two rounds of four data grants then one instruction grant
    drive_i(32'h400, 32'h0, 4'h0);
    drive_d(32'h3000, 32'hA000_0000, 4'h3);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_grant(1'b0, 32'h3000 + 32'(4 * (4 * r + k)), 32'hA000_0000, 4'h3);
        exp_done(1'b0, 32'(100 + 4 * r + k));
        serve(0, 32'(100 + 4 * r + k), 1'b0, 1'b0);
        dmemory_addr = 32'h3000 + 32'(4 * (4 * r + k + 1));
      end
      exp_grant(1'b1, 32'h400 + 32'(4 * r), 32'h0, 4'h0);
      exp_done(1'b1, 32'(200 + r));
      serve(0, 32'(200 + r), 1'b0, 1'b0);
      imemory_addr = 32'h404;
    end
    imemory_valid = 1'b0;
    dmemory_valid = 1'b0;
    tick();
    // instruction side withdraws after grant
    drive_i(32'h500, 32'h0, 4'h0);
    exp_grant(1'b1, 32'h500, 32'h0, 4'h0);
    wait_grant();
    imemory_valid = 1'b0;
    repeat (3) begin
      tick();
      check("abort_hold", {memory_valid, memory_addr, 36'd0}, {1'b1, 32'h500, 36'd0});
    end
    memory_ready = 1'b1;
    tick();
    memory_ready = 1'b0;
    check("abort_done_idle", {68'd0, memory_valid}, 69'd0);
    tick();
    // data side drops valid in the same cycle as memory_ready
    drive_d(32'h600, 32'h0, 4'h0);
    exp_grant(1'b0, 32'h600, 32'h0, 4'h0);
    wait_grant();
    tick();
    memory_ready = 1'b1;
    dmemory_valid = 1'b0;
    tick();
    memory_ready = 1'b0;
    check("same_cycle_drop_idle", {68'd0, memory_valid}, 69'd0);
    tick();
    // reset during BUSY_D after the counter has reached the limit
    drive_i(32'h800, 32'h0, 4'h0);
    drive_d(32'h700, 32'h0, 4'h1);
    for (int k = 0; k < 3; k++) begin
      exp_grant(1'b0, 32'h700, 32'h0, 4'h1);
      exp_done(1'b0, 32'(300 + k));
      serve(0, 32'(300 + k), 1'b0, 1'b0);
    end
    exp_grant(1'b0, 32'h700, 32'h0, 4'h1);
    wait_grant();
    rst = 1'b1;
    imemory_valid = 1'b0;
    dmemory_valid = 1'b0;
    memory_rdata = 32'hA5A5_A5A5;
    tick();
    check("midreset_outputs", {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb, imemory_ready, dmemory_ready}, '0);
    check("midreset_rdata_pass", {5'd0, imemory_rdata, dmemory_rdata}, {5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5});
    rst = 1'b0;
    memory_ready = 1'b1;
    tick();
    memory_ready = 1'b0;
    check("idle_ready_ignored", {68'd0, memory_valid}, 69'd0);
    drive_i(32'h900, 32'h0, 4'h0);
    drive_d(32'h704, 32'h5555_AAAA, 4'hC);
    exp_grant(1'b0, 32'h704, 32'h5555_AAAA, 4'hC);
    exp_done(1'b0, 32'h400);
    exp_grant(1'b1, 32'h900, 32'h0, 4'h0);
    exp_done(1'b1, 32'h401);
    serve(1, 32'h400, 1'b0, 1'b1);
    serve(1, 32'h401, 1'b1, 1'b0);
    repeat (3) tick();
    check("grants_left", 69'(eg.size()), 69'd0);
    check("completions_left", 69'(ed.size()), 69'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
